mem_arbiter: RTL and testbench



---
 rtl/mem_arbiter.sv | 123 ++++++++++++
 tb/tb_mem_arbiter.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Shares one single-port synchronous memory between instruction fetch and data ports.
// Data wins by default; a pending fetch is forced through after MAX_DATA_RUN data grants.
module mem_arbiter #(
    parameter int ADDR_W       = 11,
    parameter int MAX_DATA_RUN = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [31:0]       if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [31:0]       if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [31:0]       d_addr,
    input  logic [31:0]       d_wdata,
    input  logic [3:0]        d_be,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [31:0]       d_rdata,
    output logic              d_err,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_be,
    input  logic [31:0]       mem_rdata
);

    typedef enum logic [1:0] {
        RESP_NONE,
        RESP_IF,
        RESP_D,
        RESP_DERR
    } resp_t;

    localparam logic [3:0] RUN_LIMIT = 4'(MAX_DATA_RUN);

    resp_t      resp_owner;
    resp_t      resp_next;
    logic       err_read;
    logic       err_read_next;
    logic [3:0] run_cnt;
    logic       d_oor;
    logic       fetch_forced;
    logic       grant_if;
    logic       grant_d;
    logic       unused_addr_bits;

    // Fetch addresses are truncated silently; byte offsets are never used.
    assign unused_addr_bits = ^{if_addr[31:ADDR_W+2], if_addr[1:0], d_addr[1:0]};
    assign d_oor            = (d_addr[31:ADDR_W+2] != '0);

    // Nothing is granted while reset is held so every output reads zero.
    always_comb begin
        fetch_forced = if_req && (run_cnt == RUN_LIMIT);
        grant_d      = !rst && d_req && !fetch_forced;
        grant_if     = !rst && if_req && !grant_d;
    end

    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_be    = 4'h0;
        if (grant_if) begin
            mem_en    = 1'b1;
            mem_addr  = if_addr[ADDR_W+1:2];
            mem_wdata = d_wdata;
            mem_be    = 4'hF;
        end else if (grant_d) begin
            // An out-of-range access is consumed without touching memory.
            mem_en    = !d_oor;
            mem_we    = d_we && !d_oor;
            mem_addr  = d_addr[ADDR_W+1:2];
            mem_wdata = d_wdata;
            mem_be    = d_we ? d_be : 4'hF;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            resp_owner <= RESP_NONE;
            err_read   <= 1'b0;
        end else begin
            resp_owner <= resp_next;
            err_read   <= err_read_next;
        end
    end

    always_comb begin
        resp_next     = RESP_NONE;
        err_read_next = 1'b0;
        if (grant_if) begin
            resp_next = RESP_IF;
        end else if (grant_d && d_oor) begin
            resp_next     = RESP_DERR;
            err_read_next = !d_we;
        end else if (grant_d && !d_we) begin
            resp_next = RESP_D;
        end

        if_gnt    = grant_if;
        d_gnt     = grant_d;
        if_rvalid = !rst && (resp_owner == RESP_IF);
        if_rdata  = if_rvalid ? mem_rdata : 32'h0;
        d_rvalid  = !rst && ((resp_owner == RESP_D) || ((resp_owner == RESP_DERR) && err_read));
        d_rdata   = (!rst && (resp_owner == RESP_D)) ? mem_rdata : 32'h0;
        d_err     = !rst && (resp_owner == RESP_DERR);
    end

    // Counts data grants that overtook a waiting fetch.
    always_ff @(posedge clk) begin
        if (rst || !if_req || grant_if) begin
            run_cnt <= 4'd0;
        end else if (grant_d && (run_cnt != RUN_LIMIT)) begin
            run_cnt <= run_cnt + 4'd1;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a transaction-level model checks every cycle,
// and hand-computed literals pin the key scenarios.
module tb_mem_arbiter;

    localparam int ADDR_W       = 11;
    localparam int MAX_DATA_RUN = 4;
    localparam int MEM_WORDS    = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              rst;
    logic              if_req;
    logic [31:0]       if_addr;
    logic              if_gnt;
    logic              if_rvalid;
    logic [31:0]       if_rdata;
    logic              d_req;
    logic              d_we;
    logic [31:0]       d_addr;
    logic [31:0]       d_wdata;
    logic [3:0]        d_be;
    logic              d_gnt;
    logic              d_rvalid;
    logic [31:0]       d_rdata;
    logic              d_err;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [3:0]        mem_be;
    logic [31:0]       mem_rdata;

    int tests_run = 0;
    int tests_failed = 0;

    mem_arbiter #(.ADDR_W(ADDR_W), .MAX_DATA_RUN(MAX_DATA_RUN)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Shared synchronous SRAM the arbiter drives.
    logic [31:0] sram [0:MEM_WORDS-1];
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) begin
                for (int b = 0; b < 4; b++)
                    if (mem_be[b]) sram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
            end else begin
                mem_rdata <= sram[mem_addr];
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    string grant_log;

    task automatic checkLog(input string name, input string expected);
        tests_run++;
        if (grant_log != expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %s expected %s", name, grant_log, expected);
        end
    endtask

    // Reference model: its own memory image, a queue-free one-deep pending response,
    // and a count of data grants that overtook a waiting fetch.
    typedef enum int {P_NONE, P_IF, P_D, P_ERR} pend_t;
    logic [31:0] ref_mem [0:MEM_WORDS-1];
    pend_t       pend_kind = P_NONE;
    logic        pend_read = 1'b0;
    logic [31:0] pend_data = 32'h0;
    int          streak = 0;
    logic        win_d, win_i, oor, exp_en;
    int          wi;

    always @(negedge clk) begin
        if (rst) begin
            checkOutput("rst_gnt", {if_gnt, d_gnt}, 0);
            checkOutput("rst_mem", {mem_en, mem_we, mem_be}, 0);
            checkOutput("rst_maddr", 32'(mem_addr), 0);
            checkOutput("rst_wdata", mem_wdata, 0);
            checkOutput("rst_resp", {if_rvalid, d_rvalid, d_err}, 0);
            checkOutput("rst_rdata", if_rdata | d_rdata, 0);
            pend_kind = P_NONE;
            streak = 0;
        end else begin
            checkOutput("if_rvalid", 32'(if_rvalid), 32'(pend_kind == P_IF));
            checkOutput("if_rdata", if_rdata, (pend_kind == P_IF) ? pend_data : 32'h0);
            checkOutput("d_rvalid", 32'(d_rvalid), 32'((pend_kind == P_D) || (pend_kind == P_ERR && pend_read)));
            checkOutput("d_rdata", d_rdata, (pend_kind == P_D) ? pend_data : 32'h0);
            checkOutput("d_err", 32'(d_err), 32'(pend_kind == P_ERR));

            win_d  = d_req && !(if_req && streak >= MAX_DATA_RUN);
            win_i  = if_req && !win_d;
            oor    = (d_addr >> (ADDR_W + 2)) != 0;
            exp_en = win_i || (win_d && !oor);
            checkOutput("if_gnt", 32'(if_gnt), 32'(win_i));
            checkOutput("d_gnt", 32'(d_gnt), 32'(win_d));
            checkOutput("mem_en", 32'(mem_en), 32'(exp_en));
            checkOutput("mem_we", 32'(mem_we), 32'(win_d && !oor && d_we));
            if (exp_en) begin
                checkOutput("mem_addr", 32'(mem_addr), ((win_i ? if_addr : d_addr) >> 2) % MEM_WORDS);
                checkOutput("mem_be", 32'(mem_be), (win_d && d_we) ? 32'(d_be) : 32'hF);
                checkOutput("mem_wdata", mem_wdata, d_wdata);
            end
            grant_log = {grant_log, win_i ? "I" : (win_d ? "D" : "-")};

            pend_kind = P_NONE;
            if (win_i) begin
                pend_kind = P_IF;
                pend_data = ref_mem[(if_addr >> 2) % MEM_WORDS];
            end else if (win_d && oor) begin
                pend_kind = P_ERR;
                pend_read = !d_we;
            end else if (win_d) begin
                wi = int'((d_addr >> 2) % MEM_WORDS);
                if (d_we) begin
                    for (int b = 0; b < 4; b++)
                        if (d_be[b]) ref_mem[wi][8*b +: 8] = d_wdata[8*b +: 8];
                end else begin
                    pend_kind = P_D;
                    pend_data = ref_mem[wi];
                end
            end
            if (!if_req || win_i) streak = 0;
            else if (win_d) streak = streak + 1;
        end
    end

    task automatic applyStimulus(input logic r, input logic ir, input logic [31:0] ia,
                                 input logic dr, input logic dw, input logic [31:0] da,
                                 input logic [31:0] dwd, input logic [3:0] db);
        @(posedge clk);
        #1;
        rst = r; if_req = ir; if_addr = ia;
        d_req = dr; d_we = dw; d_addr = da; d_wdata = dwd; d_be = db;
        @(negedge clk);
        #1;
    endtask

    task automatic idle();
        applyStimulus(0, 0, 32'h0, 0, 0, 32'h0, 32'h0, 4'h0);
    endtask

    initial begin
        for (int i = 0; i < MEM_WORDS; i++) begin
            sram[i]    = {16'hC0DE, 16'(i)};
            ref_mem[i] = {16'hC0DE, 16'(i)};
        end
        sram[4]  = 32'hDEADBEEF; ref_mem[4]  = 32'hDEADBEEF;
        sram[8]  = 32'hCAFE0008; ref_mem[8]  = 32'hCAFE0008;
        sram[17] = 32'h11223344; ref_mem[17] = 32'h11223344;
        mem_rdata = 32'h0;
        rst = 1; if_req = 0; if_addr = 0; d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0; d_be = 0;

        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(1, 1, 32'h10, 1, 0, 32'h20, 0, 0);
        idle();

        // Fetch only
        applyStimulus(0, 1, 32'h10, 0, 0, 0, 0, 0);
        checkOutput("lit_fetch_gnt", 32'(if_gnt), 1);
        checkOutput("lit_fetch_addr", 32'(mem_addr), 4);
        idle();
        checkOutput("lit_fetch_rvalid", 32'(if_rvalid), 1);
        checkOutput("lit_fetch_rdata", if_rdata, 32'hDEADBEEF);

        // Simultaneous requests, then fetch follows with no bubble
        applyStimulus(0, 1, 32'h30, 1, 0, 32'h20, 0, 0);
        checkOutput("lit_sim_gnt", {if_gnt, d_gnt}, 32'b01);
        applyStimulus(0, 1, 32'h30, 0, 0, 0, 0, 0);
        checkOutput("lit_sim_rdata", d_rdata, 32'hCAFE0008);
        checkOutput("lit_sim_ifgnt", 32'(if_gnt), 1);
        idle();

        // Starvation guard
        grant_log = "";
        for (int c = 0; c < 10; c++)
            applyStimulus(0, 1, 32'h40 + 32'(4 * c), 1, 0, 32'h80, 0, 0);
        checkLog("lit_starve_seq", "DDDDIDDDDI");
        idle();

        // Byte write then read back
        applyStimulus(0, 0, 0, 1, 1, 32'h44, 32'h0000AB00, 4'b0010);
        checkOutput("lit_bw_be", 32'(mem_be), 32'h2);
        applyStimulus(0, 0, 0, 1, 0, 32'h44, 0, 0);
        checkOutput("lit_bw_norv", 32'(d_rvalid), 0);
        idle();
        checkOutput("lit_bw_rdata", d_rdata, 32'h1122AB44);

        // Out-of-range read and write
        applyStimulus(0, 0, 0, 1, 0, 32'h2000, 0, 0);
        checkOutput("lit_oor_gnt", {d_gnt, mem_en}, 32'b10);
        applyStimulus(0, 0, 0, 1, 1, 32'h2000, 32'hFFFFFFFF, 4'hF);
        checkOutput("lit_oor_rd_resp", {d_err, d_rvalid}, 32'b11);
        checkOutput("lit_oor_rd_data", d_rdata, 0);
        checkOutput("lit_oor_wr_en", 32'(mem_en), 0);
        applyStimulus(0, 0, 0, 1, 0, 32'h0, 0, 0);
        checkOutput("lit_oor_wr_resp", {d_err, d_rvalid}, 32'b10);
        idle();
        checkOutput("lit_oor_unchanged", d_rdata, 32'hC0DE0000);

        // Reset mid-read, with a partial data run that reset must forget
        applyStimulus(0, 1, 32'h10, 1, 0, 32'h20, 0, 0);
        applyStimulus(0, 1, 32'h10, 1, 0, 32'h20, 0, 0);
        applyStimulus(0, 1, 32'h10, 0, 0, 0, 0, 0);
        checkOutput("lit_rst_pre_gnt", 32'(if_gnt), 1);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("lit_rst_cyc_rv", 32'(if_rvalid), 0);
        idle();
        checkOutput("lit_rst_next_rv", 32'(if_rvalid), 0);
        applyStimulus(0, 1, 32'h10, 1, 0, 32'h20, 0, 0);
        applyStimulus(0, 1, 32'h10, 1, 0, 32'h20, 0, 0);
        applyStimulus(1, 1, 32'h10, 1, 0, 32'h20, 0, 0);
        grant_log = "";
        for (int c = 0; c < 5; c++)
            applyStimulus(0, 1, 32'h10, 1, 0, 32'h20, 0, 0);
        checkLog("lit_rst_runcnt", "DDDDI");
        idle();
        idle();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
